datapath_pipe: RTL and testbench

//  Parametrised two-stage successor of the single-cycle register-file + ALU datapath.

---
 rtl/datapath_pipe.sv | 130 +++++++++++++
 tb/tb_datapath_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage register-file + ALU datapath.
//   Issue stage : reads two operands combinationally from the register file
//                 and captures them with the opcode and destination into EX.
//   EX stage    : computes the ALU op, writes back, and registers
//                 result/zero_flag/wb_reg/wb_en with a one-cycle out_valid.
// Build option:
//   DATAPATH_PIPE_FWD_EN defined   -> the EX ALU output is bypassed into the
//                                     issue operands on a RAW hazard.
//   DATAPATH_PIPE_FWD_EN undefined -> on a RAW hazard in_ready drops for one
//                                     cycle so the EX op writes back first.
// Ports:
//   clock, reset (sync, active high)
//   in_valid/in_ready                     issue handshake
//   read_reg_num1/2, write_reg [RW]       source and destination registers
//   alu_control [4], regwrite             opcode and write enable
//   out_valid, result [XLEN], zero_flag   retired op
//   wb_reg [RW], wb_en                    retired op destination / write (debug)
module datapath_pipe #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] read_reg_num1,
    input  logic [$clog2(NREGS)-1:0] read_reg_num2,
    input  logic [$clog2(NREGS)-1:0] write_reg,
    input  logic [3:0]               alu_control,
    input  logic                     regwrite,
    output logic                     out_valid,
    output logic [XLEN-1:0]          result,
    output logic                     zero_flag,
    output logic [$clog2(NREGS)-1:0] wb_reg,
    output logic                     wb_en
);
    localparam int RW     = $clog2(NREGS);
    localparam int RW_SH  = $clog2(XLEN);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [RW-1:0]   rd;
        logic            rw;
    } ex_t;

    logic [NREGS-1:0][XLEN-1:0] rf;
    ex_t                        ex;
    // vld_pipe[0]: EX holds a live op; vld_pipe[1]: retire slot (out_valid)
    logic [STAGES:0]            vld_pipe;

    logic [XLEN-1:0]  rf_a, rf_b, op_a, op_b, alu_out;
    logic [RW_SH-1:0] sh;
    logic             ex_wr, haz_a, haz_b, accept;

    // Register 0 is hardwired to zero when ZERO_REG is set
    assign rf_a = (ZERO_REG != 0 && read_reg_num1 == '0) ? '0 : rf[read_reg_num1];
    assign rf_b = (ZERO_REG != 0 && read_reg_num2 == '0) ? '0 : rf[read_reg_num2];

    // The EX op will actually change the register file at the next edge
    assign ex_wr = vld_pipe[0] && ex.rw && !(ZERO_REG != 0 && ex.rd == '0);
    assign haz_a = ex_wr && (ex.rd == read_reg_num1);
    assign haz_b = ex_wr && (ex.rd == read_reg_num2);

`ifdef DATAPATH_PIPE_FWD_EN
    assign op_a     = haz_a ? alu_out : rf_a;
    assign op_b     = haz_b ? alu_out : rf_b;
    assign in_ready = !reset;
`else
    // Hold the dependent op one cycle; the register file is current next cycle
    assign op_a     = rf_a;
    assign op_b     = rf_b;
    assign in_ready = !reset && !(haz_a || haz_b);
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[STAGES];
    assign sh        = ex.b[RW_SH-1:0];

    always_comb begin
        alu_out = '0;
        case (ex.op)
            4'b0000: alu_out = ex.a & ex.b;
            4'b0001: alu_out = ex.a | ex.b;
            4'b0010: alu_out = ex.a + ex.b;
            4'b0011: alu_out = ex.a << sh;
            4'b0100: alu_out = ex.a ^ ex.b;
            4'b0101: alu_out = ex.a >> sh;
            4'b0110: alu_out = ex.a - ex.b;
            4'b0111: alu_out = {{(XLEN-1){1'b0}}, ($signed(ex.a) < $signed(ex.b))};
            4'b1000: alu_out = $signed(ex.a) >>> sh;
            4'b1100: alu_out = ~(ex.a | ex.b);
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf        <= '0;
            ex        <= '0;
            vld_pipe  <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
            wb_reg    <= '0;
            wb_en     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            if (accept) begin
                ex.a  <= op_a;
                ex.b  <= op_b;
                ex.op <= alu_control;
                ex.rd <= write_reg;
                ex.rw <= regwrite;
            end
            // Outputs hold their last value when nothing retires
            if (vld_pipe[0]) begin
                if (ex_wr)
                    rf[ex.rd] <= alu_out;
                result    <= alu_out;
                zero_flag <= (alu_out == '0);
                wb_reg    <= ex.rd;
                wb_en     <= ex_wr;
            end
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe (default parameters, ZERO_REG=1).
// An in-order architectural model executes every accepted op immediately
// and queues the expected retirement; the DUT's out_valid stream is matched
// against that queue. Directed vectors live in a table; hazard, reset and
// register-dump sequences are written out by hand.
module tb_datapath_pipe;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RW    = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [RW-1:0]   read_reg_num1 = '0, read_reg_num2 = '0, write_reg = '0;
    logic [3:0]      alu_control = '0;
    logic            regwrite = 1'b0;
    logic            out_valid, zero_flag, wb_en;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   wb_reg;

    datapath_pipe #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
        .out_valid(out_valid), .result(result), .zero_flag(zero_flag),
        .wb_reg(wb_reg), .wb_en(wb_en)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [RW-1:0]   rd;
        logic            wben;
        int              edg;
    } exp_t;

    typedef struct {
        logic [3:0]      op;
        int              a, b, d;
        logic            rw;
        logic [XLEN-1:0] res;
        logic            z, wben;
    } vec_t;

    exp_t            q[$];
    logic [XLEN-1:0] rf_m [NREGS];
    int              checks = 0, failures = 0, edge_cnt = 0;
    logic [XLEN-1:0] last_res;
    logic            last_zero, last_wben;
    logic            rdy_seen, first_ready;
    int              ret_edges[$];
    logic [XLEN-1:0] ret_res[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Opcode semantics from plain arithmetic
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int unsigned     sh;
        logic [XLEN-1:0] msb, fill;
        sh   = b % XLEN;
        msb  = {1'b1, {(XLEN-1){1'b0}}};
        fill = a[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a << sh;
            4'h4: return a ^ b;
            4'h5: return a >> sh;
            4'h6: return a - b;
            4'h7: return {{(XLEN-1){1'b0}}, ((a ^ msb) < (b ^ msb))};
            4'h8: return (a >> sh) | fill;
            4'hC: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic model_exec(input logic [3:0] op, input int a, input int b, input int d,
                              input logic rw);
        logic [XLEN-1:0] va, vb, r;
        logic            we;
        exp_t            e;
        va = (a == 0) ? '0 : rf_m[a];
        vb = (b == 0) ? '0 : rf_m[b];
        r  = ref_alu(op, va, vb);
        we = rw && (d != 0);
        if (we) rf_m[d] = r;
        e.res = r; e.rd = d[RW-1:0]; e.wben = we; e.edg = edge_cnt;
        q.push_back(e);
    endtask

    task automatic check_out(input logic in_rst);
        exp_t e;
        if (in_rst) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_result", result, '0);
            chk("rst_wb_en", wb_en, 1'b0);
            return;
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("zero_flag", zero_flag, (e.res == '0));
                chk("wb_reg", wb_reg, e.rd);
                chk("wb_en", wb_en, e.wben);
                chk("latency", edge_cnt - e.edg, 1);
                last_res = result; last_zero = zero_flag; last_wben = wb_en;
                ret_edges.push_back(edge_cnt);
                ret_res.push_back(result);
            end
        end else if (q.size() > 0 && q[0].edg < edge_cnt) begin
            chk("missing_out_valid", out_valid, 1'b1);
            void'(q.pop_front());
        end
    endtask

    // One clock: drive at negedge, decide accept, model at posedge, check at posedge+1
    task automatic step(input logic v, input logic [3:0] op, input int a, input int b,
                        input int d, input logic rw, output logic acc);
        logic rst_now;
        in_valid = v; alu_control = op; regwrite = rw;
        read_reg_num1 = a[RW-1:0]; read_reg_num2 = b[RW-1:0]; write_reg = d[RW-1:0];
        #1;
        rdy_seen = in_ready;
        rst_now  = reset;
        acc      = v && in_ready && !reset;
        @(posedge clock);
        edge_cnt++;
        if (rst_now) begin
            q.delete();
            for (int i = 0; i < NREGS; i++) rf_m[i] = '0;
        end else if (acc) begin
            model_exec(op, a, b, d, rw);
        end
        #1;
        check_out(rst_now);
        @(negedge clock);
    endtask

    task automatic issue(input logic [3:0] op, input int a, input int b, input int d,
                         input logic rw);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) begin
            step(1'b1, op, a, b, d, rw, acc);
            if (t == 0) first_ready = rdy_seen;
        end
        if (!acc) chk("issue_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, 4'h0, 0, 0, 0, 1'b0, acc);
    endtask

    // Build a constant from r30 == 1 by shift-and-or
    task automatic load_const(input int d, input logic [XLEN-1:0] val);
        logic started;
        started = 1'b0;
        issue(4'h6, d, d, d, 1'b1);
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (started) issue(4'h3, d, 30, d, 1'b1);
            if (val[i]) begin
                issue(4'h1, d, 30, d, 1'b1);
                started = 1'b1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[16];
        logic acc, r3_ready, r4_ready;

        vt[0]  = '{4'h8, 1, 2, 10, 1'b1, 32'hF800_0000, 1'b0, 1'b1};
        vt[1]  = '{4'h5, 1, 2, 11, 1'b1, 32'h0800_0000, 1'b0, 1'b1};
        vt[2]  = '{4'h7, 1, 2, 12, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
        vt[3]  = '{4'h7, 2, 1, 12, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vt[4]  = '{4'h2, 31, 30, 13, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vt[5]  = '{4'hF, 1, 2, 14, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vt[6]  = '{4'h0, 1, 31, 15, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vt[7]  = '{4'h1, 1, 2, 16, 1'b1, 32'h8000_0004, 1'b0, 1'b1};
        vt[8]  = '{4'h4, 31, 2, 17, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1};
        vt[9]  = '{4'h3, 2, 2, 18, 1'b1, 32'h0000_0040, 1'b0, 1'b1};
        vt[10] = '{4'hC, 1, 2, 19, 1'b1, 32'h7FFF_FFFB, 1'b0, 1'b1};
        vt[11] = '{4'h6, 2, 30, 20, 1'b1, 32'h0000_0003, 1'b0, 1'b1};
        vt[12] = '{4'h9, 1, 2, 21, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vt[13] = '{4'h2, 1, 2, 0, 1'b1, 32'h8000_0004, 1'b0, 1'b0};
        vt[14] = '{4'h6, 30, 31, 22, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vt[15] = '{4'h8, 2, 30, 23, 1'b1, 32'h0000_0002, 1'b0, 1'b1};

        @(negedge clock);
        idle(2);
        reset = 1'b0;

        // Constants: r31 = -1, r30 = 1
        issue(4'hC, 0, 0, 31, 1'b1);
        issue(4'h6, 0, 31, 30, 1'b1);

        // Basic ADD / SUB with zero flag
        load_const(1, 5);
        load_const(2, 7);
        issue(4'h2, 1, 2, 3, 1'b1);
        idle(2);
        chk("t2_add", last_res, 12);
        chk("t2_add_z", last_zero, 1'b0);
        issue(4'h6, 3, 3, 4, 1'b1);
        idle(2);
        chk("t2_sub", last_res, 0);
        chk("t2_sub_z", last_zero, 1'b1);

        // Back-to-back dependent ADDs
        ret_edges.delete(); ret_res.delete();
        issue(4'h2, 1, 2, 3, 1'b1);
        issue(4'h2, 3, 3, 5, 1'b1);
        r3_ready = first_ready;
        idle(3);
        chk("t3_retired", ret_edges.size(), 2);
        if (ret_edges.size() == 2) begin
            chk("t3_res0", ret_res[0], 12);
            chk("t3_res1", ret_res[1], 24);
`ifdef DATAPATH_PIPE_FWD_EN
            chk("t3_ready", r3_ready, 1'b1);
            chk("t3_gap", ret_edges[1] - ret_edges[0], 1);
`else
            chk("t3_ready", r3_ready, 1'b0);
            chk("t3_gap", ret_edges[1] - ret_edges[0], 2);
`endif
        end

        // Write to r0 is dropped and does not stall a reader of r0
        issue(4'h2, 1, 2, 0, 1'b1);
        issue(4'h1, 0, 0, 6, 1'b1);
        r4_ready = first_ready;
        idle(2);
        chk("t4_ready", r4_ready, 1'b1);
        chk("t4_r0", last_res, 0);

        // Shift / compare / opcode table
        load_const(1, 32'h8000_0000);
        load_const(2, 4);
        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].rw);
            idle(2);
            chk($sformatf("tbl%0d_res", i), last_res, vt[i].res);
            chk($sformatf("tbl%0d_z", i), last_zero, vt[i].z);
            chk($sformatf("tbl%0d_wben", i), last_wben, vt[i].wben);
        end

        // Random stream, in_valid toggling, hazard-dense register choice
        for (int n = 0; n < 500; n++) begin
            int ra, rb, rd;
            ra = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
            rb = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
            rd = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
            step(($urandom % 4) != 0, 4'($urandom % 16), ra, rb, rd, ($urandom % 5) != 0, acc);
        end
        idle(3);
        for (int r = 0; r < NREGS; r++) begin
            issue(4'h1, r, r, r, 1'b0);
            idle(2);
            chk($sformatf("rf_dump_r%0d", r), last_res, rf_m[r]);
        end

        // Reset mid-stream with an op in EX
        issue(4'hC, 0, 0, 7, 1'b1);
        reset = 1'b1;
        step(1'b1, 4'h2, 1, 2, 8, 1'b1, acc);
        step(1'b1, 4'h2, 1, 2, 8, 1'b1, acc);
        reset = 1'b0;
        issue(4'h1, 7, 7, 9, 1'b0);
        chk("post_reset_ready", first_ready, 1'b1);
        idle(2);
        chk("post_reset_r7", last_res, 0);
        for (int r = 1; r < NREGS; r++) begin
            issue(4'h1, r, r, r, 1'b0);
            idle(2);
            chk($sformatf("rst_rf_r%0d", r), last_res, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
